// File: rtl/cargador_instrucciones.sv
// Program loader: packs a big-endian byte stream into 32-bit instruction words,
// writes them to consecutive word addresses and holds the CPU in reset until loaded.
module cargador_instrucciones #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        words_q, words_d;

  logic              take;
  logic [7:0]        words_inc;

  assign take      = rx_valid & rx_ready;
  assign words_inc = words_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    words_d = words_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (take) begin
          n_d     = rx_data;
          idx_d   = '0;
          addr_d  = '0;
          words_d = '0;
          if (rx_data == 8'd0)               state_d = S_DONE;
          else if (32'(rx_data) > MAX_WORDS) state_d = S_ERR;
          else                               state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (take) begin
          word_d = {word_q[23:0], rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        // The address is held on the final word so it never runs past the last slot.
        if (words_inc == n_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(4);
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_ready     = (state_q == S_HDR) || (state_q == S_RECV);
  assign mem_we       = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = word_q;
  assign cpu_rst_n    = (state_q == S_DONE);
  assign busy         = (state_q == S_HDR) || (state_q == S_RECV) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Bench for cargador_instrucciones: vector table of load sessions, random sessions
// and hand-written reset/reload sequences, checked against a byte-stream model.
module tb_cargador_instrucciones;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [31:0] mem_wdata;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] words_loaded;

  cargador_instrucciones #(.ADDR_W(9), .MAX_WORDS(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;       // 0: fixed example bytes, 1: random bytes, 2: all 0xFF
    int n;
    int gap;        // percent chance of withholding rx_valid
    bit strays;     // inject start pulses while busy
    int exp_words;
    bit exp_done;
    bit exp_err;
  } vec_t;

  int total = 0;
  int bad = 0;
  byte unsigned stream[$];
  logic [8:0]  got_addr[$];
  logic [31:0] got_data[$];
  int s_last_we;
  int s_rise;
  vec_t vecs[8];
  byte unsigned basic_bytes[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {26'd0, rx_ready, mem_we, cpu_rst_n, busy, done, error}, 32'd0);
    check({name, "_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_wdata"}, mem_wdata, 32'd0);
    check({name, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic build_stream(input int kind, input int n);
    stream.delete();
    stream.push_back(8'(n));
    if (n <= 128) begin
      for (int i = 0; i < 4 * n; i++) begin
        if (kind == 0)      stream.push_back(basic_bytes[i % 8]);
        else if (kind == 2) stream.push_back(8'hFF);
        else                stream.push_back(8'($urandom_range(255)));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("after_start", {27'd0, busy, done, error, cpu_rst_n, rx_ready}, 32'b10001);
  endtask

  // Called just after an edge; feeds the stream and records what the DUT does.
  task automatic drive(input int gap, input bit strays, input int stop_writes);
    int idx = 0;
    int cyc = 0;
    int viol = 0;
    int budget;
    bit prev_cpu;
    budget = stream.size() * 10 + 50;
    prev_cpu = cpu_rst_n;
    s_last_we = -1;
    s_rise = -1;
    got_addr.delete();
    got_data.delete();
    forever begin
      if (mem_we) begin
        got_addr.push_back(mem_addr);
        got_data.push_back(mem_wdata);
        s_last_we = cyc;
        if (rx_ready) viol++;
      end
      if (busy && cpu_rst_n) viol++;
      if (!prev_cpu && cpu_rst_n && s_rise < 0) s_rise = cyc;
      prev_cpu = cpu_rst_n;
      if (stop_writes >= 0 && got_addr.size() == stop_writes) break;
      if (idx == stream.size() && !busy) break;
      if (cyc > budget) begin
        total++;
        bad++;
        $display("FAIL session_timeout: got %0d bytes consumed expected %0d", idx, stream.size());
        break;
      end
      if (idx < stream.size() && $urandom_range(99) >= gap) begin
        rx_valid = 1'b1;
        rx_data  = stream[idx];
      end else begin
        rx_valid = (idx >= stream.size()) ? 1'($urandom_range(1)) : 1'b0;
        rx_data  = 8'($urandom_range(255));
      end
      if (rx_valid && rx_ready) begin
        if (idx < stream.size()) idx++;
        else viol++;
      end
      start = strays && busy && ($urandom_range(7) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    rx_valid = 1'b0;
    start = 1'b0;
    check("protocol_violations", viol, 0);
  endtask

  task automatic check_writes(input int n);
    logic [31:0] w;
    check("write_count", got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      w = {stream[1 + 4*i], stream[2 + 4*i], stream[3 + 4*i], stream[4 + 4*i]};
      check($sformatf("addr[%0d]", i), 32'(got_addr[i]), 32'(4 * i));
      check($sformatf("data[%0d]", i), got_data[i], w);
    end
  endtask

  task automatic run_vec(input vec_t v);
    build_stream(v.kind, v.n);
    pulse_start();
    drive(v.gap, v.strays, -1);
    check_writes(v.exp_words);
    check("words_loaded", 32'(words_loaded), 32'(v.exp_words));
    check("done", 32'(done), 32'(v.exp_done));
    check("error", 32'(error), 32'(v.exp_err));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(v.exp_done));
    if (v.exp_words > 0) check("rise_latency", s_rise - s_last_we, 1);
    if (!v.exp_done) check("cpu_never_released", s_rise, -1);
  endtask

  initial begin
    vec_t rv;
    int idle_bad;
    basic_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    vecs[0] = '{0, 2,   0,  1'b0, 2,   1'b1, 1'b0};
    vecs[1] = '{0, 2,   50, 1'b1, 2,   1'b1, 1'b0};
    vecs[2] = '{1, 0,   30, 1'b0, 0,   1'b1, 1'b0};
    vecs[3] = '{1, 128, 20, 1'b1, 128, 1'b1, 1'b0};
    vecs[4] = '{1, 129, 0,  1'b0, 0,   1'b0, 1'b1};
    vecs[5] = '{1, 1,   40, 1'b0, 1,   1'b1, 1'b0};
    vecs[6] = '{2, 1,   0,  1'b0, 1,   1'b1, 1'b0};
    vecs[7] = '{1, 7,   60, 1'b1, 7,   1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    check("idle_ignores_valid", {30'd0, rx_ready, busy}, 32'd0);
    rx_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    for (int r = 0; r < 6; r++) begin
      rv.kind = 1;
      rv.n = $urandom_range(24, 1);
      rv.gap = $urandom_range(70);
      rv.strays = 1'($urandom_range(1));
      rv.exp_words = rv.n;
      rv.exp_done = 1'b1;
      rv.exp_err = 1'b0;
      run_vec(rv);
    end

    // Reset in the middle of a three-word session, right on the second write.
    build_stream(1, 3);
    pulse_start();
    drive(20, 1'b1, 2);
    check_writes(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    idle_bad = 0;
    rx_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rx_ready || busy || mem_we) idle_bad++;
    end
    rx_valid = 1'b0;
    check("post_reset_idle", idle_bad, 0);
    rv = '{1, 3, 10, 1'b1, 3, 1'b1, 1'b0};
    run_vec(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cargador_instrucciones.md
Name: cargador_instrucciones

Overview:
Program loader that sits directly upstream of the pipelined datapath's instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit word, most significant byte first (MIPS big-endian). Each word is written into instruction memory at consecutive byte addresses (0, 4, 8, ...). The CPU is held in reset until the whole program is loaded, then released so the PC starts fetching from address 0.

Parameters:
ADDR_W, 9, instruction-memory byte-address width (matches the 9-bit PC).
MAX_WORDS, 128, largest program accepted, in words (2^ADDR_W / 4).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
start  input  1  one-cycle pulse; begins a load session.
rx_data  input  8  incoming program byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader can accept a byte this cycle.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  byte address of the word being written (multiple of 4).
mem_wdata  output  32  word being written.
cpu_rst_n  output  1  active-low reset to the datapath (PC, buffers); low while not loaded.
busy  output  1  load session in progress.
done  output  1  program loaded; CPU running.
error  output  1  header word count exceeded MAX_WORDS.
words_loaded  output  8  number of words written in the current/last session.

Behaviour:
- Byte transfer: a byte is transferred only on a cycle where rx_valid=1 and rx_ready=1. rx_valid may stay high across cycles; each handshake consumes exactly one byte.
- Reset (rst_n=0 on an edge): state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0, words_loaded=0.
- Reset mid-session: abandons the session immediately. Words already written stay in memory; all outputs return to their reset values.
- IDLE: rx_ready=0. start=1 -> HDR.
- HDR:
  - rx_ready=1, busy=1. The first accepted byte is N, the program length in words (unsigned).
  - N=0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - Otherwise latch N, clear the byte index, mem_addr and words_loaded -> RECV.
- RECV:
  - rx_ready=1. Each accepted byte shifts into a 32-bit assembly register; the first byte lands in bits 31:24.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1; mem_addr and mem_wdata hold the assembled word.
  - Next cycle: mem_addr += 4, words_loaded += 1.
  - If words_loaded+1 == N -> DONE, else -> RECV.
  - Bytes are never lost: rx_ready is low during WRITE.
- DONE:
  - done=1, busy=0, cpu_rst_n=1, rx_ready=0, mem_we=0.
  - cpu_rst_n rises on the cycle after the final WRITE cycle, never earlier.
  - start=1 -> HDR on the next edge, with cpu_rst_n=0 and done=0 from that edge (reload).
- ERR:
  - error=1, cpu_rst_n=0, rx_ready=0, no memory writes.
  - start=1 -> HDR with error cleared.
- Other start pulses: ignored in HDR, RECV and WRITE.
- rx_valid outside HDR/RECV: ignored; no byte is consumed.
- Addresses: mem_addr never exceeds 4*(MAX_WORDS-1), so no wrap-around can occur. The counter is ADDR_W bits wide, and mem_addr[1:0] is always 0.
- Throughput and latency:
  - Minimum 5 cycles per word (4 byte handshakes plus 1 write cycle).
  - The final word's mem_we comes 1 cycle after its 4th byte handshake; cpu_rst_n rises 1 cycle after that.

Test Plan:
- Basic load: reset, start, bytes 02,20,08,00,05,8C,09,00,04 with rx_valid held high -> two writes (addr 0 data 0x20080005; addr 4 data 0x8C090004), words_loaded=2, done=1, cpu_rst_n=1 one cycle after the second mem_we.
- Backpressure and gaps: same stream with rx_valid toggling 1,0,0,1 randomly -> identical writes; rx_ready=0 exactly during each WRITE cycle; no byte dropped or duplicated.
- Boundaries:
  - N=0 -> DONE with no mem_we.
  - N=128 (512 data bytes) -> last write at addr 0x1FC, words_loaded=128.
  - N=129 -> error=1, no mem_we, cpu_rst_n=0; a following start plus valid N=1 clears error and loads one word.
- Reload: from DONE, start with N=1, word 0xFFFFFFFF -> cpu_rst_n drops the cycle after start; single write at addr 0; done reasserts.
- Reset mid-operation: rst_n=0 after 2 of 3 words -> all outputs at reset values next edge; stray start pulses during RECV have no effect.
